// File: rtl/fir_coef_loader.sv
// fir_coef_loader: coefficient bank and load sequencer for the transposed FIR.
// Streams L taps serially into the filter, then passes samples through.
module fir_coef_loader #(
    parameter int W1 = 9,
    parameter int L  = 15,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [W1-1:0] cfg_data,
    input  logic                 load_req,
    input  logic                 s_valid,
    input  logic signed [W1-1:0] s_data,
    output logic                 load_x,
    output logic signed [W1-1:0] c_out,
    output logic signed [W1-1:0] x_out,
    output logic                 busy,
    output logic                 load_done,
    output logic [15:0]          drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(L - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         k_q, k_d;
    logic                  first_q, first_d;
    logic signed [W1-1:0]  bank_q [L];

    logic                  load_x_q, load_x_d;
    logic signed [W1-1:0]  c_out_q, c_out_d;
    logic signed [W1-1:0]  x_out_q, x_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           drop_q, drop_d;

    logic                  wr_ok;

    // The bank is frozen while it is being streamed out
    assign wr_ok = cfg_we && (state_q != LOAD) && (cfg_addr <= LAST);

    // State, tap counter and first-RUN-cycle flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            first_q <= first_d;
        end
    end

    // Next state: load_req only starts a load outside LOAD
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        first_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            LOAD: begin
                if (k_q == LAST) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            RUN: begin
                if (load_req) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; all outputs are registered below
    always_comb begin
        load_x_d = 1'b1;
        c_out_d  = '0;
        x_out_d  = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        drop_d   = drop_q;
        unique case (state_q)
            LOAD: begin
                load_x_d = 1'b0;
                busy_d   = 1'b1;
                c_out_d  = bank_q[k_q];
                if (s_valid && (drop_q != 16'hFFFF)) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            RUN: begin
                x_out_d = s_valid ? s_data : '0;
                done_d  = first_q;
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_x_q <= 1'b1;
            c_out_q  <= '0;
            x_out_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            load_x_q <= load_x_d;
            c_out_q  <= c_out_d;
            x_out_q  <= x_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    // Coefficient bank, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_ok) begin
            bank_q[cfg_addr] <= cfg_data;
        end
    end

    assign load_x    = load_x_q;
    assign c_out     = c_out_q;
    assign x_out     = x_out_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: randomized bench with a behavioural bank/drop model
// and a small serial-coefficient FIR model fed from the loader outputs.
module tb_fir_coef_loader;

    localparam int W1 = 9;
    localparam int L  = 15;
    localparam int AW = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic signed [W1-1:0] cfg_data;
    logic                 load_req;
    logic                 s_valid;
    logic signed [W1-1:0] s_data;
    logic                 load_x;
    logic signed [W1-1:0] c_out;
    logic signed [W1-1:0] x_out;
    logic                 busy;
    logic                 load_done;
    logic [15:0]          drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic signed [W1-1:0] mbank [L];
    int                   mdrop;
    int                   fchain [L];

    fir_coef_loader #(.W1(W1), .L(L), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .load_req  (load_req),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .load_x    (load_x),
        .c_out     (c_out),
        .x_out     (x_out),
        .busy      (busy),
        .load_done (load_done),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic signed [W1-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we = 1'b0;
        if (int'(a) < L) mbank[a] = d;
    endtask

    // wr_k: -2 none, -1 together with load_req, 0..L-1 during that load cycle
    task automatic run_load(input bit from_run, input bit sv, input int wr_k,
                            input int req_k, input logic [AW-1:0] wa,
                            input logic signed [W1-1:0] wd);
        logic signed [W1-1:0] ex;
        load_req = 1'b1;
        s_valid  = sv;
        s_data   = W1'($urandom);
        if (wr_k == -1) begin
            cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
            if (int'(wa) < L) mbank[wa] = wd;
        end
        ex = (from_run && sv) ? s_data : '0;
        step();
        load_req = 1'b0;
        cfg_we   = 1'b0;
        total_cnt++;
        if ({load_x, x_out} !== {1'b1, ex}) begin
            $display("FAIL req_edge load_x/x_out got %b/%0d want 1/%0d", load_x, x_out, ex);
        end else pass_cnt++;
        for (int k = 0; k < L; k++) begin
            s_data   = W1'($urandom);
            load_req = (k == req_k);
            if (k == wr_k) begin
                cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
            end
            step();
            load_req = 1'b0;
            cfg_we   = 1'b0;
            if (sv && mdrop < 65535) mdrop++;
            for (int i = 0; i < L - 1; i++) fchain[i] = fchain[i+1];
            fchain[L-1] = int'(c_out);
            total_cnt++;
            if ({load_x, busy, c_out, x_out, load_done} !== {1'b0, 1'b1, mbank[k], {W1{1'b0}}, 1'b0}) begin
                $display("FAIL load_cyc%0d lx=%b busy=%b c=%0d x=%0d done=%b want c=%0d",
                         k, load_x, busy, c_out, x_out, load_done, mbank[k]);
            end else pass_cnt++;
        end
        s_data = W1'($urandom);
        ex = sv ? s_data : '0;
        step();
        total_cnt++;
        if ({load_x, busy, load_done, c_out, x_out} !== {1'b1, 1'b0, 1'b1, {W1{1'b0}}, ex}) begin
            $display("FAIL done_cyc lx=%b busy=%b done=%b c=%0d x=%0d want x=%0d",
                     load_x, busy, load_done, c_out, x_out, ex);
        end else pass_cnt++;
        total_cnt++;
        if (drop_cnt !== 16'(mdrop)) begin
            $display("FAIL drop_cnt got %0d want %0d", drop_cnt, mdrop);
        end else pass_cnt++;
        s_valid = 1'b0;
        step();
        total_cnt++;
        if ({load_done, busy, x_out} !== {1'b0, 1'b0, {W1{1'b0}}}) begin
            $display("FAIL after_done done=%b busy=%b x=%0d want 0/0/0", load_done, busy, x_out);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        load_req = 0; s_valid = 0; s_data = 0;
        mdrop = 0;
        for (int i = 0; i < L; i++) begin
            mbank[i] = '0;
            fchain[i] = 0;
        end
        #3;
        total_cnt++;
        if ({load_x, c_out, x_out, busy, load_done, drop_cnt} !== {1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 16'd0}) begin
            $display("FAIL reset_vals lx=%b c=%0d x=%0d busy=%b done=%b drop=%0d",
                     load_x, c_out, x_out, busy, load_done, drop_cnt);
        end else pass_cnt++;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_basic_load();
        for (int k = 0; k < L; k++) begin
            s_valid = 1'b1;
            s_data  = W1'($urandom);
            do_write(AW'(k), W1'(k + 1));
            total_cnt++;
            if ({x_out, drop_cnt, load_x} !== {9'd0, 16'd0, 1'b1}) begin
                $display("FAIL idle_ignore x=%0d drop=%0d lx=%b want 0/0/1", x_out, drop_cnt, load_x);
            end else pass_cnt++;
        end
        s_valid = 1'b0;
        run_load(1'b0, 1'b0, -2, -2, '0, '0);
    endtask

    task automatic test_filter();
        int xh [L];
        int y;
        int ey;
        for (int k = 0; k < L; k++) begin
            xh[k] = 0;
            total_cnt++;
            if (fchain[k] != int'(mbank[k])) begin
                $display("FAIL tap%0d got %0d want %0d", k, fchain[k], mbank[k]);
            end else pass_cnt++;
        end
        for (int n = 0; n < L + 2; n++) begin
            if (n == 0) begin
                s_valid = 1'b1; s_data = 9'sd1;
            end else if (n % 2 == 1) begin
                s_valid = 1'b0; s_data = W1'($urandom);
            end else begin
                s_valid = 1'b1; s_data = '0;
            end
            step();
            for (int i = L - 1; i > 0; i--) xh[i] = xh[i-1];
            xh[0] = int'(x_out);
            y = 0;
            for (int k = 0; k < L; k++) y += fchain[k] * xh[k];
            ey = (n < L) ? int'(mbank[n]) : 0;
            total_cnt++;
            if (y !== ey) begin
                $display("FAIL impulse_y%0d got %0d want %0d", n, y, ey);
            end else pass_cnt++;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_drop_reload();
        run_load(1'b1, 1'b1, -2, -2, '0, '0);
    endtask

    task automatic test_cfg();
        run_load(1'b1, 1'b0, 5, -2, 4'd3, -9'sd5);
        run_load(1'b1, 1'b0, -1, -2, 4'd3, -9'sd5);
        do_write(4'd15, 9'sd77);
        do_write(4'd7, W1'($urandom));
        run_load(1'b1, 1'b0, -2, -2, '0, '0);
    endtask

    task automatic test_saturate();
        while (mdrop + 15 <= 65535 - 10) begin
            load_req = 1'b1;
            s_valid  = 1'b1;
            s_data   = W1'($urandom);
            step();
            load_req = 1'b0;
            repeat (L) step();
            mdrop += 15;
        end
        s_valid = 1'b0;
        step(); step();
        total_cnt++;
        if (drop_cnt !== 16'(mdrop)) begin
            $display("FAIL drop_preset got %0d want %0d", drop_cnt, mdrop);
        end else pass_cnt++;
        run_load(1'b1, 1'b1, -2, 7, '0, '0);
        run_load(1'b1, 1'b1, -2, 3, '0, '0);
    endtask

    task automatic test_reset_mid_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        #1;
        mdrop = 0;
        for (int i = 0; i < L; i++) mbank[i] = '0;
        total_cnt++;
        if ({load_x, c_out, x_out, busy, load_done, drop_cnt} !== {1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 16'd0}) begin
            $display("FAIL midload_reset lx=%b c=%0d x=%0d busy=%b done=%b drop=%0d",
                     load_x, c_out, x_out, busy, load_done, drop_cnt);
        end else pass_cnt++;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if ({load_done, busy, load_x} !== 3'b001) begin
                $display("FAIL post_reset%0d done=%b busy=%b lx=%b want 0/0/1", i, load_done, busy, load_x);
            end else pass_cnt++;
        end
        run_load(1'b0, 1'b0, -2, -2, '0, '0);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_filter();
        test_drop_reload();
        test_cfg();
        test_saturate();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
